// File: rtl/serial_digit_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package serial_digit_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned digit_count(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // A single-digit operation still needs a one-bit counter.
  function automatic int unsigned count_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_digit_adder_digit_full_adder.sv
// Combinational DIGIT-bit ripple cell: sum digit, carry into the top bit and carry out.
module digit_full_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_dig,
  output logic             c_top,
  output logic             c_out
);

  logic carry;

  always_comb begin
    carry = c_in;
    c_top = c_in;
    s_dig = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (i == int'(DIGIT) - 1) c_top = carry;
      s_dig[i] = a_dig[i] ^ b_dig[i] ^ carry;
      carry    = (a_dig[i] & b_dig[i]) | (carry & (a_dig[i] ^ b_dig[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial adder: WIDTH-bit operands summed DIGIT bits per clock with valid/ready handshakes.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b - cin).
import serial_digit_adder_pkg::*;

module serial_digit_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = digit_count(WIDTH, DIGIT);
  localparam int unsigned CW = count_width(N);

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic            carry_q;
  logic [CW-1:0]   cnt;
  logic            last_dig;
  logic [DIGIT-1:0] s_dig;
  logic            c_top, c_out;

  assign last_dig = (cnt == CW'(N - 1));

  digit_full_adder #(.DIGIT(DIGIT)) u_cell (
    .a_dig (a_sh[DIGIT-1:0]),
    .b_dig (b_sh[DIGIT-1:0]),
    .c_in  (carry_q),
    .s_dig (s_dig),
    .c_top (c_top),
    .c_out (c_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_dig) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh <= a;
          cnt  <= '0;
`ifdef SERIAL_ADD_SUB_EN
          // Subtraction as a + ~b + ~cin, so cout reads as "no borrow".
          b_sh    <= sub ? ~b : b;
          carry_q <= sub ? ~cin : cin;
`else
          b_sh    <= b;
          carry_q <= cin;
`endif
        end
        RUN: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          sum     <= (sum >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
          carry_q <= c_out;
          cnt     <= cnt + CW'(1);
          if (last_dig) begin
            cout <= c_out;
            ovf  <= c_top ^ c_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: DIGIT=1 and DIGIT=4 instances against an arithmetic reference model.
module tb_serial_digit_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid_s [2];
  logic       in_ready_s [2];
  logic [7:0] a_s [2];
  logic [7:0] b_s [2];
  logic       cin_s [2];
  logic       sub_s [2];
  logic       out_valid_s [2];
  logic       out_ready_s [2];
  logic [7:0] sum_s [2];
  logic       cout_s [2];
  logic       ovf_s [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub_s[0]),
`endif
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .sum(sum_s[0]), .cout(cout_s[0]), .ovf(ovf_s[0])
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub_s[1]),
`endif
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .sum(sum_s[1]), .cout(cout_s[1]), .ovf(ovf_s[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, overflow when the signed result leaves [-128,127].
  function automatic void ref_model(input logic [7:0] a, input logic [7:0] b, input logic ci,
                                    input logic su, output logic [7:0] s, output logic co,
                                    output logic ov);
    int u, r, sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!su) begin
      u  = int'(a) + int'(b) + int'(ci);
      co = (u > 255);
      r  = sa + sb + int'(ci);
    end else begin
      u  = int'(a) - int'(b) - int'(ci);
      co = (u >= 0);
      r  = sa - sb - int'(ci);
    end
    s  = u[7:0];
    ov = (r > 127) || (r < -128);
  endfunction

  task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic su, input int hold, input bit poke, input int exp_lat);
    logic [7:0] es;
    logic       ec, eo;
    int         lat;
`ifndef SERIAL_ADD_SUB_EN
    su = 1'b0;
`endif
    ref_model(a, b, ci, su, es, ec, eo);
    check_val("idle_ready", in_ready_s[idx], 1);
    a_s[idx] = a; b_s[idx] = b; cin_s[idx] = ci; sub_s[idx] = su;
    in_valid_s[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[idx] = poke;
    check_val("accept_ready_low", in_ready_s[idx], 0);
    lat = 0;
    while (!out_valid_s[idx] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", lat, exp_lat);
    check_val("sum", sum_s[idx], es);
    check_val("cout", cout_s[idx], ec);
    check_val("ovf", ovf_s[idx], eo);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_val("hold_sum", sum_s[idx], es);
      check_val("hold_flags", {cout_s[idx], ovf_s[idx]}, {ec, eo});
      check_val("hold_ready_low", in_ready_s[idx], 0);
      check_val("hold_valid", out_valid_s[idx], 1);
    end
    out_ready_s[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[idx] = 1'b0;
    check_val("handoff_ready", in_ready_s[idx], 1);
    check_val("handoff_valid", out_valid_s[idx], 0);
    in_valid_s[idx] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0;
      a_s[i] = '0; b_s[i] = '0; cin_s[i] = 1'b0; sub_s[i] = 1'b0;
    end
    #12;
    check_val("rst_sum", sum_s[0], 0);
    check_val("rst_valid", out_valid_s[0], 0);
    check_val("rst_ready", in_ready_s[0], 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, 8);
    do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0, 8);
    do_op(1, 8'hA5, 8'h5B, 1'b1, 1'b0, 0, 1'b0, 2);
    do_op(0, 8'h3C, 8'h4D, 1'b1, 1'b0, 5, 1'b1, 8);
    do_op(1, 8'h80, 8'h80, 1'b0, 1'b0, 5, 1'b1, 2);
`ifdef SERIAL_ADD_SUB_EN
    do_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0, 8);
    do_op(1, 8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0, 2);
`endif

    // Abort an operation three cycles into RUN.
    a_s[0] = 8'hA5; b_s[0] = 8'h3C; cin_s[0] = 1'b1; sub_s[0] = 1'b0;
    in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check_val("midrun_rst_sum", sum_s[0], 0);
    check_val("midrun_rst_flags", {cout_s[0], ovf_s[0], out_valid_s[0]}, 0);
    check_val("midrun_rst_ready", in_ready_s[0], 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, 8'h10, 8'h20, 1'b0, 1'b0, 0, 1'b0, 8);

    for (int n = 0; n < 60; n++) begin
      int idx;
      idx = n % 2;
      do_op(idx, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom), (idx == 0) ? 8 : 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_digit_adder.md
# serial_digit_adder

Multi-cycle, parametrised successor to the single-bit full adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through one shared DIGIT-bit ripple cell and a carry flip-flop. It sits on the arithmetic datapath wherever area matters more than latency. Valid/ready handshakes on input and output allow stalling. Flags report carry-out and signed overflow.

## Interface
- WIDTH, 8, operand/sum width; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle; N = WIDTH/DIGIT cycles per operation.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  operands and cin are valid.
- in_ready  out  1  block can accept; combinational, equals (state==IDLE).
- a, b  in  WIDTH each  operands.
- cin  in  1  carry-in (borrow-in in subtract mode).
- sub  in  1  subtract select; present only with SERIAL_ADD_SUB_EN.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on in_valid&&in_ready, latch a, b into shift registers, carry FF <= cin, digit counter <= 0, state -> RUN.
- RUN: each cycle the cell adds the low DIGIT bits of a_sh and b_sh plus the carry FF. The sum digit shifts into sum from the MSB end. a_sh and b_sh shift right by DIGIT. Carry FF updates. Counter increments.
- On the last digit (counter==N-1):
  - capture the cell's carry into the top bit as msb_cin;
  - state -> DONE;
  - cout <= final carry;
  - ovf <= msb_cin ^ final carry.
- DONE: out_valid=1. sum, cout and ovf are held stable until out_ready=1, then state -> IDLE.
- Inputs are ignored outside IDLE; in_valid during RUN/DONE has no effect.
- No bypass: a new operation cannot be accepted in the same cycle as the DONE->IDLE handoff.
- Reset (any time, including mid-RUN): state IDLE, out_valid=0, sum=0, cout=0, ovf=0, carry FF=0, counter=0, shift registers=0. The in-flight operation is discarded.

## Timing
- Handshake accepted at edge k. Digits 0..N-1 are processed at edges k+1..k+N. out_valid is high after edge k+N, giving latency N cycles.
- in_ready falls after edge k. It rises again after the edge at which out_valid&&out_ready.
- Throughput: one result per N+2 cycles with out_ready tied high.
- Counter width: $clog2(N), minimum 1 bit. N=1 is legal: RUN lasts one cycle.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - sub port exists and is latched with the operands at acceptance.
  - sub=1 computes a - b - cin: b is inverted on load, carry FF <= ~cin.
  - cout is the raw carry (1 = no borrow). ovf is per the formula above.
- Undefined: no sub port, addition only, with no inverter logic.

## Structure
- Package serial_digit_adder_pkg holds the state typedef (enum IDLE/RUN/DONE) and a function computing N and the counter width.
- Sub-module digit_full_adder: a combinational DIGIT-bit ripple chain of full-adder equations. It outputs sum digit, carry into the top bit, and carry out. One instance.

## Test plan
- WIDTH=8, DIGIT=1, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; out_valid exactly 8 cycles after the accept edge.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- WIDTH=8, DIGIT=4, a=0xA5, b=0x5B, cin=1 -> sum=0x01, cout=1, ovf=0; latency 2 cycles.
- Backpressure: out_ready held low 5 cycles after out_valid, and a new in_valid is pulsed during RUN. Required: sum/cout/ovf stable, the new request not accepted, in_ready=0 until out_ready.
- Reset asserted at RUN cycle 3, then the op a=0x10, b=0x20 is issued. Required: all outputs 0 immediately, in_ready=1, next result sum=0x30 with a clean carry.
- SERIAL_ADD_SUB_EN, sub=1, a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0, ovf=0.
